hazard_stall_ctrl: RTL and testbench

//  Drives the control side of the D/E/M/W pipeline registers: PC/D enables, D/E flushes and forwarding selects.

---
 rtl/hazard_stall_ctrl_pkg.sv | 51 +++++
 rtl/hazard_stall_ctrl_md_busy_ctr.sv | 51 +++++
 rtl/hazard_stall_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
//   Shared constants and types for the D/E/M/W hazard and stall controller.
//   - Forwarding select codes seen by the datapath muxes.
//   - Tuse / Tnew encodings produced by the D-stage decoder.
//   - Shadow-pipeline entry types: the full E entry and the reduced
//     destination-only entry kept for M and W.
//   - tnew_dec(): saturating "one stage older" step for Tnew.
// ----------------------------------------------------------------------------
package hazard_pkg;

    // Forwarding mux select codes
    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    // Tuse: cycles from D until the operand is consumed; 3 means unused
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles after entering E until the result exists
    localparam logic [1:0] TNEW_NONE = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Shadow entry for the E stage: everything the hazard logic looks at.
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       is_md;
        logic       md_div;
    } shadow_t;

    // M and W only ever act as producers, so only the destination side
    // of the entry travels past E.
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } dest_t;

    localparam shadow_t SHADOW_BUBBLE = '0;
    localparam dest_t   DEST_BUBBLE   = '0;

    // Tnew as seen one stage later; a result that already exists stays at 0.
    function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
        return (tnew == 2'd0) ? 2'd0 : (tnew - 2'd1);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_ctr.sv
// ----------------------------------------------------------------------------
// md_busy_ctr
//   Occupancy counter for the multi-cycle mult/div unit. When a mult/div
//   instruction sits in E at a clock edge the counter loads its latency;
//   otherwise it counts down to zero. busy is high while the count is nonzero.
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset (clears the count at once)
//   load      in   mult/div instruction present in E this cycle
//   load_div  in   qualifies load: 1 = div latency, 0 = mult latency
//   busy      out  unit occupied
// ----------------------------------------------------------------------------
module md_busy_ctr
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic load_div,
    output logic busy
);

    localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = load_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign busy = (cnt_reg != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Control side of the D/E/M/W pipeline registers. A shadow pipeline moves
//   in lockstep with E/M/W and carries each instruction's destination and
//   Tnew; comparing it with the D-stage operand indices and Tuse yields the
//   stall, flush and forwarding decisions in the same cycle (purely
//   combinational from the shadow state and the D inputs). No datapath here.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   d_rs, d_rt                 D-stage source indices
//   d_tuse_rs, d_tuse_rt       cycles until each source is consumed (3 = unused)
//   d_dst, d_tnew              D-stage destination (0 = none) and its Tnew
//   d_md_start, d_md_div       D instruction is mult/div, and which kind
//   d_md_use                   D instruction touches HI/LO
//   flush_req                  redirect/exception, squashes D and E
//   en_pc, en_d                PC and regD write enables
//   flush_d, flush_e           regD / regE clears
//   md_busy                    mult/div unit occupied
//   fwd_rs_d, fwd_rt_d         D-stage forwarding selects
//   fwd_rs_e, fwd_rt_e         E-stage forwarding selects
// ----------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    input  logic       flush_req,
    output logic       en_pc,
    output logic       en_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic       md_busy,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e
);

    // ------------------------------------------------------------------
    // Shadow pipeline
    // ------------------------------------------------------------------
    shadow_t e_reg, e_next;
    dest_t   m_reg, m_next;
    dest_t   w_reg, w_next;

    always_comb begin
        w_next      = m_reg;
        w_next.tnew = tnew_dec(m_reg.tnew);

        m_next.dst  = e_reg.dst;
        m_next.tnew = tnew_dec(e_reg.tnew);

        e_next = SHADOW_BUBBLE;
        if (!flush_e) begin
            e_next.dst    = d_dst;
            e_next.tnew   = d_tnew;
            e_next.rs     = d_rs;
            e_next.rt     = d_rt;
            e_next.is_md  = d_md_start;
            e_next.md_div = d_md_div;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_reg <= SHADOW_BUBBLE;
            m_reg <= DEST_BUBBLE;
            w_reg <= DEST_BUBBLE;
        end else begin
            e_reg <= e_next;
            m_reg <= m_next;
            w_reg <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Mult/div occupancy
    // ------------------------------------------------------------------
    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (e_reg.is_md),
        .load_div (e_reg.md_div),
        .busy     (md_busy)
    );

    // ------------------------------------------------------------------
    // Per-source hazard and forwarding (index 0 = rs, 1 = rt)
    // ------------------------------------------------------------------
    logic [4:0] src_d     [2];
    logic [1:0] tuse_d    [2];
    logic [4:0] src_e     [2];
    logic       src_stall [2];
    logic [1:0] fwd_d_sel [2];
    logic [1:0] fwd_e_sel [2];

    assign src_d[0]  = d_rs;
    assign src_d[1]  = d_rt;
    assign tuse_d[0] = d_tuse_rs;
    assign tuse_d[1] = d_tuse_rt;
    assign src_e[0]  = e_reg.rs;
    assign src_e[1]  = e_reg.rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic hit_e_d;
            logic hit_m_d;
            logic hit_m_e;
            logic hit_w_e;

            // $0 is hard-wired, so a zero index never matches anything;
            // this also keeps bubbles (dst=0) from ever matching.
            assign hit_e_d = (src_d[gi] != 5'd0) && (e_reg.dst == src_d[gi]);
            assign hit_m_d = (src_d[gi] != 5'd0) && (m_reg.dst == src_d[gi]);
            assign hit_m_e = (src_e[gi] != 5'd0) && (m_reg.dst == src_e[gi]);
            assign hit_w_e = (src_e[gi] != 5'd0) && (w_reg.dst == src_e[gi]);

            // Stall while the producer still needs more cycles than the
            // consumer has left before it reads the operand.
            assign src_stall[gi] = (tuse_d[gi] != TUSE_NONE) &&
                                   ((hit_e_d && (e_reg.tnew > tuse_d[gi])) ||
                                    (hit_m_d && (m_reg.tnew > tuse_d[gi])));

            // The nearest matching stage owns the register: if its result
            // is not ready yet, an older stage's copy is stale and must not
            // be forwarded.
            assign fwd_d_sel[gi] = hit_e_d ? ((e_reg.tnew == 2'd0) ? FWD_E : FWD_GRF) :
                                   hit_m_d ? ((m_reg.tnew == 2'd0) ? FWD_M : FWD_GRF) :
                                             FWD_GRF;

            assign fwd_e_sel[gi] = hit_m_e ? ((m_reg.tnew == 2'd0) ? FWD_M : FWD_GRF) :
                                   hit_w_e ? ((w_reg.tnew == 2'd0) ? FWD_W : FWD_GRF) :
                                             FWD_GRF;
        end
    endgenerate

    assign fwd_rs_d = fwd_d_sel[0];
    assign fwd_rt_d = fwd_d_sel[1];
    assign fwd_rs_e = fwd_e_sel[0];
    assign fwd_rt_e = fwd_e_sel[1];

    // ------------------------------------------------------------------
    // Stall / flush decision
    // ------------------------------------------------------------------
    logic data_stall;
    logic md_stall;
    logic stall;

    assign data_stall = src_stall[0] | src_stall[1];
    // HI/LO accesses wait for a running op and also for one that is only
    // just entering E (the counter has not loaded yet).
    assign md_stall   = d_md_use && (md_busy || e_reg.is_md);
    assign stall      = data_stall | md_stall;

    always_comb begin
        en_pc   = 1'b1;
        en_d    = 1'b1;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (flush_req) begin
            // Redirect wins: the stalled instruction is being discarded.
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (stall) begin
            en_pc   = 1'b0;
            en_d    = 1'b0;
            flush_e = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
    import hazard_pkg::*;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use, flush_req;
    logic       en_pc, en_d, flush_d, flush_e, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_md_use(d_md_use), .flush_req(flush_req),
        .en_pc(en_pc), .en_d(en_d), .flush_d(flush_d), .flush_e(flush_e), .md_busy(md_busy),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the last three issued instructions with their Tnew at
    // issue; age k (0 = E, 1 = M, 2 = W) has k cycles less to go. The
    // mult/div unit is free once the cycle number passes busy_until.
    typedef struct {
        int dst; int tnew; int rs; int rt; bit md; bit dv;
    } ins_t;
    ins_t hist [3];
    int   cyc;
    int   busy_until;

    // Observations of the last step, for scenario-level checks
    logic obs_en_pc, obs_flush_d, obs_flush_e, obs_busy;
    logic [1:0] obs_fwd_rs_d, obs_fwd_rs_e;

    function automatic int rem(int k);
        int r;
        r = hist[k].tnew - k;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit dstall(int r, int tuse);
        if (r == 0 || tuse == 3) return 1'b0;
        return (hist[0].dst == r && rem(0) > tuse) || (hist[1].dst == r && rem(1) > tuse);
    endfunction

    function automatic int fwd_d_m(int r);
        if (r == 0) return 0;
        if (hist[0].dst == r) return (rem(0) == 0) ? 1 : 0;
        if (hist[1].dst == r) return (rem(1) == 0) ? 2 : 0;
        return 0;
    endfunction

    function automatic int fwd_e_m(int r);
        if (r == 0) return 0;
        if (hist[1].dst == r) return (rem(1) == 0) ? 2 : 0;
        if (hist[2].dst == r) return (rem(2) == 0) ? 3 : 0;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0, 1'b0, 1'b0};
        busy_until = -1;
    endtask

    task automatic set_d(input int rs, input int rt, input int tu_rs, input int tu_rt,
                         input int dst, input int tnew, input bit mds, input bit mdd, input bit mdu);
        d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(tu_rs); d_tuse_rt = 2'(tu_rt);
        d_dst = 5'(dst); d_tnew = 2'(tnew);
        d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // One cycle: inputs already driven after the falling edge; check outputs,
    // clock, then advance the model.
    task automatic step();
        bit mbusy, stall, fe;
        logic [3:0] ctrl_exp;
        logic [7:0] fwd_exp;
        #1;
        mbusy = (cyc <= busy_until);
        stall = dstall(d_rs, d_tuse_rs) || dstall(d_rt, d_tuse_rt) ||
                (d_md_use && (mbusy || hist[0].md));
        if (flush_req)  ctrl_exp = 4'b1111;
        else if (stall) ctrl_exp = 4'b0001;
        else            ctrl_exp = 4'b1100;
        fe = ctrl_exp[0];
        fwd_exp = {2'(fwd_d_m(d_rs)), 2'(fwd_d_m(d_rt)),
                   2'(fwd_e_m(hist[0].rs)), 2'(fwd_e_m(hist[0].rt))};
        check("ctrl{en_pc,en_d,flush_d,flush_e}", {4'b0, en_pc, en_d, flush_d, flush_e}, {4'b0, ctrl_exp});
        check("md_busy", {7'b0, md_busy}, {7'b0, mbusy});
        check("fwd{rs_d,rt_d,rs_e,rt_e}", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}, fwd_exp);
        obs_en_pc = en_pc; obs_flush_d = flush_d; obs_flush_e = flush_e; obs_busy = md_busy;
        obs_fwd_rs_d = fwd_rs_d; obs_fwd_rs_e = fwd_rs_e;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (hist[0].md) busy_until = cyc + (hist[0].dv ? DIV_CYC : MULT_CYC);
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (fe) hist[0] = '{0, 0, 0, 0, 1'b0, 1'b0};
            else    hist[0] = '{int'(d_dst), int'(d_tnew), int'(d_rs), int'(d_rt), d_md_start, d_md_div};
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int stalls, busy_cnt;
        cyc = 0;
        rst_n = 1'b0; flush_req = 1'b0; nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        // Reset state
        #1;
        check("reset_en", {6'b0, en_pc, en_d}, 8'h03);
        check("reset_flush", {6'b0, flush_d, flush_e}, 8'h00);
        check("reset_busy", {7'b0, md_busy}, 8'h00);
        check("reset_fwd", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}, 8'h00);
        step();

        // 1: lw $1 then beq $1 (tuse 0) -> two stall cycles
        set_d(5, 0, 1, 3, 1, 2, 1'b0, 1'b0, 1'b0); step();
        set_d(1, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_en_pc) break;
            stalls++;
        end
        check("t1_stall_cycles", 8'(stalls), 8'd2);
        nop(); step(); step();

        // 2: addu $2 then consumer of $2 (tuse 1): no stall, fwd 2 then 3 in E
        set_d(3, 4, 1, 1, 2, 1, 1'b0, 1'b0, 1'b0); step();
        set_d(2, 6, 1, 1, 5, 1, 1'b0, 1'b0, 1'b0); step();
        check("t2_no_stall", {7'b0, obs_en_pc}, 8'h01);
        set_d(2, 0, 1, 3, 7, 1, 1'b0, 1'b0, 1'b0); step();
        check("t2_fwd_rs_e_M", {6'b0, obs_fwd_rs_e}, {6'b0, FWD_M});
        nop(); step();
        check("t2_fwd_rs_e_W", {6'b0, obs_fwd_rs_e}, {6'b0, FWD_W});
        step(); step();

        // 3: div then mflo -> 1 + DIV_CYC stalls, busy exactly DIV_CYC cycles
        set_d(8, 9, 1, 1, 0, 0, 1'b1, 1'b1, 1'b0); step();
        set_d(0, 0, 3, 3, 10, 1, 1'b0, 1'b0, 1'b1);
        stalls = 0; busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (obs_busy) busy_cnt++;
            if (obs_en_pc) break;
            stalls++;
        end
        check("t3_stall_cycles", 8'(stalls), 8'(1 + DIV_CYC));
        check("t3_busy_cycles", 8'(busy_cnt), 8'(DIV_CYC));
        nop(); step(); step();

        // 4: stall and flush_req together; the flushed producer must not reach E
        set_d(5, 0, 1, 3, 1, 2, 1'b0, 1'b0, 1'b0); step();
        set_d(1, 0, 0, 3, 3, 1, 1'b0, 1'b0, 1'b0); flush_req = 1'b1; step();
        check("t4_flush_ctrl", {5'b0, obs_en_pc, obs_flush_d, obs_flush_e}, 8'h07);
        flush_req = 1'b0;
        set_d(3, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0); step();
        check("t4_e_bubble", {7'b0, obs_en_pc}, 8'h01);
        nop(); step(); step();

        // 5: dst 0 never creates a hazard
        set_d(0, 0, 3, 3, 0, 2, 1'b0, 1'b0, 1'b0); step();
        set_d(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0); step();
        check("t5_no_stall", {7'b0, obs_en_pc}, 8'h01);
        check("t5_fwd_rs_d", {6'b0, obs_fwd_rs_d}, 8'h00);
        nop(); step(); step();

        // 6: reset while a div is running with cnt=6
        set_d(8, 9, 1, 1, 0, 0, 1'b1, 1'b1, 1'b0); step();
        nop(); step();
        repeat (4) step();
        set_d(0, 0, 3, 3, 4, 2, 1'b0, 1'b0, 1'b0); rst_n = 1'b0; step();
        check("t6_busy_before_reset", {7'b0, obs_busy}, 8'h01);
        rst_n = 1'b1;
        set_d(4, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0); step();
        check("t6_busy_after_reset", {7'b0, obs_busy}, 8'h00);
        check("t6_no_stall_after_reset", {7'b0, obs_en_pc}, 8'h01);
        nop(); step();

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            flush_req = ($urandom_range(0, 7) == 0);
            set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 1), ($urandom_range(0, 4) == 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
